// File: rtl/lcd_frame_refresh_ctrl_if.sv
// rtl/lcd_frame_refresh_ctrl_if.sv - HD44780 8-bit write-only bus between controller and panel
interface lcd_frame_refresh_ctrl_if;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_DB;

  modport master (output LCD_RS, LCD_RW, LCD_E, LCD_DB);
  modport slave  (input  LCD_RS, LCD_RW, LCD_E, LCD_DB);
endinterface

// File: rtl/lcd_frame_refresh_ctrl.sv
// rtl/lcd_frame_refresh_ctrl.sv - 16x2 character LCD init and frame refresh engine
module lcd_frame_refresh_ctrl #(
  parameter int T_POWERUP_CYC = 2_000_000,
  parameter int T_EN_CYC      = 50,
  parameter int T_CMD_CYC     = 5_000,
  parameter int T_CLEAR_CYC   = 200_000
) (
  input  logic                      Clock_100MHz,
  input  logic                      Reset_n,
  input  logic [127:0]              Line_1,
  input  logic [127:0]              Line_2,
  input  logic                      Refresh_req,
  lcd_frame_refresh_ctrl_if.master  lcd,
  output logic                      Busy,
  output logic                      Frame_done
);
  localparam int MAX_A   = (T_POWERUP_CYC > T_CLEAR_CYC) ? T_POWERUP_CYC : T_CLEAR_CYC;
  localparam int MAX_B   = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {POWERUP, INIT, IDLE, ADDR1, ROW1, ADDR2, ROW2, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_SETTLE} phase_t;

  state_t         state;
  phase_t         phase;
  logic [CW-1:0]  cnt;
  logic [2:0]     init_idx;
  logic [3:0]     col;
  logic           clear_xfer;
  logic           pending;
  logic [255:0]   snap;

  logic [7:0]     snap_chr [32];
  logic [7:0]     init_cmd;
  logic [CW-1:0]  settle_last;
  logic [3:0]     col_nxt;
  logic           frame_req;

  // snap_chr[0..15] = row 0 columns, snap_chr[16..31] = row 1 columns
  for (genvar g = 0; g < 32; g++) begin : g_chr
    assign snap_chr[g] = snap[255 - 8*g -: 8];
  end

  assign lcd.LCD_RW = 1'b0;

  always_comb begin
    col_nxt     = col + 4'd1;
    settle_last = clear_xfer ? CW'(T_CLEAR_CYC - 1) : CW'(T_CMD_CYC - 1);
    frame_req   = Refresh_req || pending || ({Line_1, Line_2} != snap);
    // command following the one at init_idx
    case (init_idx)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h06;
      default:    init_cmd = 8'h01;
    endcase
  end

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= POWERUP;
      phase       <= PH_SETUP;
      cnt         <= '0;
      init_idx    <= '0;
      col         <= '0;
      clear_xfer  <= 1'b0;
      pending     <= 1'b0;
      snap        <= {32{8'h20}};
      lcd.LCD_E   <= 1'b0;
      lcd.LCD_RS  <= 1'b0;
      lcd.LCD_DB  <= 8'h00;
      Busy        <= 1'b1;
      Frame_done  <= 1'b0;
    end else begin
      Frame_done <= 1'b0;
      if (Refresh_req) pending <= 1'b1;
      case (state)
        POWERUP: begin
          if (cnt == CW'(T_POWERUP_CYC - 1)) begin
            state      <= INIT;
            init_idx   <= '0;
            cnt        <= '0;
            phase      <= PH_SETUP;
            clear_xfer <= 1'b0;
            lcd.LCD_RS <= 1'b0;
            lcd.LCD_DB <= 8'h38;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (frame_req) begin
            state      <= ADDR1;
            Busy       <= 1'b1;
            snap       <= {Line_1, Line_2};
            pending    <= 1'b0;
            phase      <= PH_SETUP;
            clear_xfer <= 1'b0;
            lcd.LCD_RS <= 1'b0;
            lcd.LCD_DB <= 8'h80;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          case (phase)
            PH_SETUP: begin
              lcd.LCD_E <= 1'b1;
              phase     <= PH_STROBE;
              cnt       <= '0;
            end
            PH_STROBE: begin
              if (cnt == CW'(T_EN_CYC - 1)) begin
                lcd.LCD_E <= 1'b0;
                phase     <= PH_SETTLE;
                cnt       <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_SETTLE: begin
              if (cnt == settle_last) begin
                // settle over: this edge is also the SETUP edge of the next transfer
                cnt        <= '0;
                phase      <= PH_SETUP;
                clear_xfer <= 1'b0;
                case (state)
                  INIT: begin
                    if (init_idx == 3'd5) begin
                      state <= IDLE;
                      Busy  <= 1'b0;
                    end else begin
                      init_idx   <= init_idx + 3'd1;
                      lcd.LCD_RS <= 1'b0;
                      lcd.LCD_DB <= init_cmd;
                      clear_xfer <= (init_idx == 3'd4);
                    end
                  end
                  ADDR1: begin
                    state      <= ROW1;
                    col        <= '0;
                    lcd.LCD_RS <= 1'b1;
                    lcd.LCD_DB <= snap_chr[5'd0];
                  end
                  ROW1: begin
                    col <= col_nxt;
                    if (col == 4'd15) begin
                      state      <= ADDR2;
                      lcd.LCD_RS <= 1'b0;
                      lcd.LCD_DB <= 8'hC0;
                    end else begin
                      lcd.LCD_RS <= 1'b1;
                      lcd.LCD_DB <= snap_chr[{1'b0, col_nxt}];
                    end
                  end
                  ADDR2: begin
                    state      <= ROW2;
                    col        <= '0;
                    lcd.LCD_RS <= 1'b1;
                    lcd.LCD_DB <= snap_chr[5'd16];
                  end
                  ROW2: begin
                    col <= col_nxt;
                    if (col == 4'd15) begin
                      state      <= DONE;
                      Frame_done <= 1'b1;
                    end else begin
                      lcd.LCD_RS <= 1'b1;
                      lcd.LCD_DB <= snap_chr[{1'b1, col_nxt}];
                    end
                  end
                  default: ;
                endcase
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: phase <= PH_SETUP;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_frame_refresh_ctrl.sv
// tb/tb_lcd_frame_refresh_ctrl.sv - directed self-checking bench for lcd_frame_refresh_ctrl
module tb_lcd_frame_refresh_ctrl;
  logic         clk = 1'b0;
  logic         Reset_n;
  logic [127:0] Line_1;
  logic [127:0] Line_2;
  logic         Refresh_req;
  logic         Busy;
  logic         Frame_done;

  lcd_frame_refresh_ctrl_if bus ();

  lcd_frame_refresh_ctrl #(
    .T_POWERUP_CYC (100),
    .T_EN_CYC      (4),
    .T_CMD_CYC     (10),
    .T_CLEAR_CYC   (20)
  ) dut (
    .Clock_100MHz (clk),
    .Reset_n      (Reset_n),
    .Line_1       (Line_1),
    .Line_2       (Line_2),
    .Refresh_req  (Refresh_req),
    .lcd          (bus),
    .Busy         (Busy),
    .Frame_done   (Frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] SPACES = {16{8'h20}};
  localparam logic [127:0] HELLO  = {"HELLO", {11{8'h20}}};
  localparam logic [127:0] AELLO  = {"AELLO", {11{8'h20}}};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // cycle number of the most recent posedge since reset release
  always @(posedge clk) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  logic       e_q      = 1'b0;
  int         e_len    = 0;
  int         e_min    = 1000;
  int         e_max    = 0;
  int         first_rise = -1;
  int         fd_cnt   = 0;
  logic       rw_bad   = 1'b0;
  logic       db_moved = 1'b0;
  logic [8:0] xhold    = 9'h000;
  logic [8:0] xq[$];

  always @(negedge clk) begin
    e_q <= bus.LCD_E;
    if (bus.LCD_RW !== 1'b0) rw_bad <= 1'b1;
    if (Frame_done) fd_cnt <= fd_cnt + 1;
    if (!Reset_n) begin
      first_rise <= -1;
      e_q        <= 1'b0;
    end else if (bus.LCD_E && !e_q) begin
      xq.push_back({bus.LCD_RS, bus.LCD_DB});
      xhold <= {bus.LCD_RS, bus.LCD_DB};
      e_len <= 1;
      if (first_rise < 0) first_rise <= cyc;
    end else if (bus.LCD_E) begin
      e_len <= e_len + 1;
      if ({bus.LCD_RS, bus.LCD_DB} != xhold) db_moved <= 1'b1;
    end else if (e_q) begin
      if (e_len < e_min) e_min <= e_len;
      if (e_len > e_max) e_max <= e_len;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_refresh();
    Refresh_req = 1'b1;
    @(negedge clk);
    Refresh_req = 1'b0;
  endtask

  task automatic wait_fd(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      @(negedge clk);
      if (Frame_done) at = cyc;
    end
  endtask

  task automatic wait_busy_low(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      @(negedge clk);
      if (!Busy) at = cyc;
    end
  endtask

  task automatic wait_xfers(input int count, input int budget, output int ok);
    ok = 0;
    for (int n = 0; n < budget && ok == 0; n++) begin
      @(negedge clk);
      if (xq.size() >= count && bus.LCD_E) ok = 1;
    end
  endtask

  task automatic check_init(input string tag, input int base);
    logic [8:0] exp_i [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h006, 9'h001};
    for (int i = 0; i < 6; i++)
      check($sformatf("%s init%0d", tag, i),
            (base + i < xq.size()) ? xq[base + i] : 9'h1FF, exp_i[i]);
  endtask

  task automatic check_frame(input string tag, input logic [127:0] l1, input logic [127:0] l2,
                             input int base);
    logic [8:0] e;
    check($sformatf("%s count", tag), xq.size(), base + 34);
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       e = 9'h080;
      else if (i < 17)  e = {1'b1, l1[127 - 8*(i-1) -: 8]};
      else if (i == 17) e = 9'h0C0;
      else              e = {1'b1, l2[127 - 8*(i-18) -: 8]};
      check($sformatf("%s x%0d", tag, i),
            (base + i < xq.size()) ? xq[base + i] : 9'h1FF, e);
    end
  endtask

  initial begin
    int t, d1, d2, s, f0, ok;
    Reset_n     = 1'b1;
    Line_1      = SPACES;
    Line_2      = SPACES;
    Refresh_req = 1'b0;
    #1 Reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst E", bus.LCD_E, 0);
    check("rst RS", bus.LCD_RS, 0);
    check("rst RW", bus.LCD_RW, 0);
    check("rst DB", bus.LCD_DB, 0);
    check("rst Busy", Busy, 1);
    check("rst Frame_done", Frame_done, 0);

    // power-up and init with blank lines: no frame afterwards
    Reset_n = 1'b1;
    wait_busy_low(400, t);
    check("t1 busy fall", t, 200);
    check("t1 first E rise", first_rise, 101);
    check_init("t1", 0);
    repeat (30) @(negedge clk);
    check("t1 no frame", xq.size(), 6);
    check("t1 busy idle", Busy, 0);

    // line change starts a frame
    xq.delete();
    Line_1 = HELLO;
    s = cyc + 1;
    wait_fd(700, d1);
    check("t2 done latency", d1 - s, 510);
    check_frame("t2", HELLO, SPACES, 0);
    @(negedge clk);
    check("t2 done width", Frame_done, 0);
    check("t2 busy fall", Busy, 0);

    // line change during ROW2 waits for the next frame
    xq.delete();
    pulse_refresh();
    wait_xfers(20, 600, ok);
    check("t3 reach row2", ok, 1);
    Line_1 = AELLO;
    wait_fd(700, d1);
    check_frame("t3a", HELLO, SPACES, 0);
    xq.delete();
    @(negedge clk);
    check("t3 busy low", Busy, 0);
    @(negedge clk);
    check("t3 restart", Busy, 1);
    wait_fd(700, d2);
    check("t3 gap", d2 - d1, 512);
    check_frame("t3b", AELLO, SPACES, 0);

    // three refresh pulses mid-frame collapse to one extra frame
    repeat (5) @(negedge clk);
    xq.delete();
    f0 = fd_cnt;
    pulse_refresh();
    repeat (50) @(negedge clk);
    pulse_refresh();
    repeat (100) @(negedge clk);
    pulse_refresh();
    repeat (150) @(negedge clk);
    pulse_refresh();
    wait_fd(700, d1);
    wait_fd(700, d2);
    check("t4 gap", d2 - d1, 512);
    repeat (600) @(negedge clk);
    check("t4 frame count", fd_cnt - f0, 2);
    check("t4 busy steady", Busy, 0);
    check("t4 xfers", xq.size(), 68);

    // refresh with unchanged lines rewrites identical data
    xq.delete();
    pulse_refresh();
    wait_fd(700, d1);
    check_frame("t6", AELLO, SPACES, 0);
    repeat (5) @(negedge clk);

    // reset mid-strobe in ROW1
    xq.delete();
    pulse_refresh();
    wait_xfers(3, 600, ok);
    check("t5 reach row1", ok, 1);
    check("t5 pre RS", bus.LCD_RS, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("t5 async E", bus.LCD_E, 0);
    check("t5 async RS", bus.LCD_RS, 0);
    check("t5 async DB", bus.LCD_DB, 0);
    check("t5 async Busy", Busy, 1);
    @(negedge clk);
    @(negedge clk);
    xq.delete();
    Reset_n = 1'b1;
    wait_busy_low(400, t);
    check("t5 busy fall", t, 200);
    check("t5 first E rise", first_rise, 101);
    @(negedge clk);
    check("t5 frame start", Busy, 1);
    wait_fd(700, d1);
    check("t5 done", d1, 711);
    check_init("t5", 0);
    check_frame("t5", AELLO, SPACES, 6);

    check("E high min", e_min, 4);
    check("E high max", e_max, 4);
    check("RW low", rw_bad, 0);
    check("DB stable in strobe", db_moved, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
